pc_ir_unit: RTL and testbench

- Program-counter and instruction-register stage of the multicycle CPU.
- Holds PC, IR and MDR, and resolves the PC write from the controller's PCWrite/PCWriteCond/BEQ/PCSrc strobes and the ALU zero flag.
- Supplies the 6-bit opcode to the controller and the decoded register/immediate fields to the datapath.

---
 rtl/pc_ir_unit.sv | 102 ++++++++++
 tb/tb_pc_ir_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// PC, IR and MDR stage of the multicycle CPU; resolves the PC write from controller strobes.
// Define PC_IR_PERF_CNT_EN to add saturating instruction and taken-branch counters.
module pc_ir_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            PCWrite_ctrl,
  input  logic            PCWriteCond_ctrl,
  input  logic            BEQ_ctrl,
  input  logic [1:0]      PCSrc_ctrl,
  input  logic            IRWrite_ctrl,
  input  logic [PC_W-1:0] alu_result_in,
  input  logic [PC_W-1:0] alu_out_in,
  input  logic            alu_zero_in,
  input  logic [31:0]     mem_data_in,
  output logic [PC_W-1:0] pc_out,
  output logic [5:0]      Instruction_ctrlOut,
  output logic [4:0]      rd_out,
  output logic [4:0]      rs_out,
  output logic [4:0]      rt_out,
  output logic [15:0]     imm_out,
  output logic [PC_W-1:0] jump_target_out,
  output logic [31:0]     mdr_out,
`ifdef PC_IR_PERF_CNT_EN
  output logic [CNT_W-1:0] instr_count_out,
  output logic [CNT_W-1:0] branch_taken_count_out,
`endif
  output logic            pc_write_en_out
);

  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [31:0]     mdr;
  logic            branchCond;
  logic            pcWriteEn;
  logic            pcLoad;
  logic [PC_W-1:0] nextPc;
  logic [PC_W-1:0] jumpTarget;

  assign jumpTarget = {pc[PC_W-1:26], ir[25:0]};

  // PCSrc 11 is reserved: even an enabled write must leave the PC untouched.
  always_comb begin
    branchCond = BEQ_ctrl ? alu_zero_in : ~alu_zero_in;
    pcWriteEn  = PCWrite_ctrl | (PCWriteCond_ctrl & branchCond);
    nextPc     = pc;
    pcLoad     = 1'b0;
    case (PCSrc_ctrl)
      2'b00: begin nextPc = alu_result_in; pcLoad = pcWriteEn; end
      2'b01: begin nextPc = alu_out_in;    pcLoad = pcWriteEn; end
      2'b10: begin nextPc = jumpTarget;    pcLoad = pcWriteEn; end
      default: begin nextPc = pc;          pcLoad = 1'b0;      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc  <= RESET_PC;
      ir  <= '0;
      mdr <= '0;
    end else begin
      if (pcLoad)       pc <= nextPc;
      if (IRWrite_ctrl) ir <= mem_data_in;
      mdr <= mem_data_in;
    end
  end

`ifdef PC_IR_PERF_CNT_EN
  logic [CNT_W-1:0] instrCount;
  logic [CNT_W-1:0] branchTakenCount;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrCount       <= '0;
      branchTakenCount <= '0;
    end else begin
      if (IRWrite_ctrl && (instrCount != '1))
        instrCount <= instrCount + 1'b1;
      if (PCWriteCond_ctrl && branchCond && !PCWrite_ctrl && (branchTakenCount != '1))
        branchTakenCount <= branchTakenCount + 1'b1;
    end
  end

  assign instr_count_out        = instrCount;
  assign branch_taken_count_out = branchTakenCount;
`endif

  assign pc_out              = pc;
  assign Instruction_ctrlOut = ir[31:26];
  assign rd_out              = ir[25:21];
  assign rs_out              = ir[20:16];
  assign rt_out              = ir[15:11];
  assign imm_out             = ir[15:0];
  assign jump_target_out     = jumpTarget;
  assign mdr_out             = mdr;
  assign pc_write_en_out     = pcWriteEn;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_ir_unit;
  localparam int PcW = 32;
`ifdef PC_IR_PERF_CNT_EN
  localparam int CntW = 4;
`else
  localparam int CntW = 16;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            PCWrite_ctrl, PCWriteCond_ctrl, BEQ_ctrl, IRWrite_ctrl, alu_zero_in;
  logic [1:0]      PCSrc_ctrl;
  logic [PcW-1:0]  alu_result_in, alu_out_in;
  logic [31:0]     mem_data_in;
  logic [PcW-1:0]  pc_out, jump_target_out;
  logic [5:0]      Instruction_ctrlOut;
  logic [4:0]      rd_out, rs_out, rt_out;
  logic [15:0]     imm_out;
  logic [31:0]     mdr_out;
  logic            pc_write_en_out;
`ifdef PC_IR_PERF_CNT_EN
  logic [CntW-1:0] instr_count_out, branch_taken_count_out;
`endif

  int compared = 0;
  int mismatched = 0;

  pc_ir_unit #(.PC_W(PcW), .RESET_PC('0), .CNT_W(CntW)) dut (
    .clock(clock), .reset(reset),
    .PCWrite_ctrl(PCWrite_ctrl), .PCWriteCond_ctrl(PCWriteCond_ctrl), .BEQ_ctrl(BEQ_ctrl),
    .PCSrc_ctrl(PCSrc_ctrl), .IRWrite_ctrl(IRWrite_ctrl),
    .alu_result_in(alu_result_in), .alu_out_in(alu_out_in), .alu_zero_in(alu_zero_in),
    .mem_data_in(mem_data_in), .pc_out(pc_out), .Instruction_ctrlOut(Instruction_ctrlOut),
    .rd_out(rd_out), .rs_out(rs_out), .rt_out(rt_out), .imm_out(imm_out),
    .jump_target_out(jump_target_out), .mdr_out(mdr_out),
`ifdef PC_IR_PERF_CNT_EN
    .instr_count_out(instr_count_out), .branch_taken_count_out(branch_taken_count_out),
`endif
    .pc_write_en_out(pc_write_en_out)
  );

  always #5 clock = ~clock;

  task automatic idleInputs();
    PCWrite_ctrl = 0; PCWriteCond_ctrl = 0; BEQ_ctrl = 0; PCSrc_ctrl = 2'b00;
    IRWrite_ctrl = 0; alu_zero_in = 0; alu_result_in = '0; alu_out_in = '0; mem_data_in = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic loadPc(input logic [31:0] value);
    idleInputs();
    PCWrite_ctrl = 1; PCSrc_ctrl = 2'b00; alu_result_in = value;
    step();
    idleInputs();
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (pc_out !== 32'h0 || Instruction_ctrlOut !== 6'b0 || mdr_out !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle cyc%0d: pc=%h op=%b mdr=%h, required 0/000000/0", i, pc_out, Instruction_ctrlOut, mdr_out);
      end
    end
  endtask

  task automatic test_fetch();
    doReset();
    mem_data_in = 32'h4A2B0000; IRWrite_ctrl = 1; PCWrite_ctrl = 1; PCSrc_ctrl = 2'b00; alu_result_in = 32'd1;
    step();
    idleInputs();
    compared++;
    if (pc_out !== 32'd1 || Instruction_ctrlOut !== 6'b010010 || rd_out !== 5'd17 || rs_out !== 5'd11) begin
      mismatched++;
      $display("[TB] FAIL fetch: pc=%h op=%b rd=%0d rs=%0d, required 1/010010/17/11", pc_out, Instruction_ctrlOut, rd_out, rs_out);
    end
    compared++;
    if (mdr_out !== 32'h4A2B0000) begin
      mismatched++;
      $display("[TB] FAIL fetch_mdr: mdr=%h, required 4a2b0000", mdr_out);
    end
  endtask

  task automatic test_branch();
    logic [31:0] expPc;
    for (int beq = 1; beq >= 0; beq--) begin
      for (int zero = 1; zero >= 0; zero--) begin
        loadPc(32'h10);
        PCWriteCond_ctrl = 1; BEQ_ctrl = 1'(beq); PCSrc_ctrl = 2'b01; alu_out_in = 32'h40; alu_zero_in = 1'(zero);
        #1;
        expPc = (beq == zero) ? 32'h40 : 32'h10;
        compared++;
        if (pc_write_en_out !== (beq == zero)) begin
          mismatched++;
          $display("[TB] FAIL branch_we beq=%0d zero=%0d: we=%b, required %b", beq, zero, pc_write_en_out, beq == zero);
        end
        step();
        idleInputs();
        compared++;
        if (pc_out !== expPc) begin
          mismatched++;
          $display("[TB] FAIL branch beq=%0d zero=%0d: pc=%h, required %h", beq, zero, pc_out, expPc);
        end
      end
    end
  endtask

  task automatic test_jump();
    PCWrite_ctrl = 1; PCSrc_ctrl = 2'b00; alu_result_in = 32'h0C000005;
    IRWrite_ctrl = 1; mem_data_in = 32'h04000123;
    step();
    idleInputs();
    compared++;
    if (jump_target_out !== 32'h0C000123) begin
      mismatched++;
      $display("[TB] FAIL jump_target: got %h, required 0c000123", jump_target_out);
    end
    PCWrite_ctrl = 1; PCSrc_ctrl = 2'b10; alu_result_in = 32'hDEAD0000;
    step();
    idleInputs();
    compared++;
    if (pc_out !== 32'h0C000123) begin
      mismatched++;
      $display("[TB] FAIL jump: pc=%h, required 0c000123", pc_out);
    end
  endtask

  task automatic test_reserved_and_async_reset();
    loadPc(32'h0000_0077);
    PCWrite_ctrl = 1; PCSrc_ctrl = 2'b11; alu_result_in = 32'h1234; alu_out_in = 32'h5678;
    IRWrite_ctrl = 1; mem_data_in = 32'hFC00_FFFF;
    step();
    idleInputs();
    compared++;
    if (pc_out !== 32'h77) begin
      mismatched++;
      $display("[TB] FAIL pcsrc11_hold: pc=%h, required 00000077", pc_out);
    end
    #2;
    reset = 1;
    #1;
    compared++;
    if (pc_out !== 32'h0 || Instruction_ctrlOut !== 6'b0 || imm_out !== 16'h0 || mdr_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: pc=%h op=%b imm=%h mdr=%h, required all 0", pc_out, Instruction_ctrlOut, imm_out, mdr_out);
    end
    step();
    reset = 0;
  endtask

  task automatic test_random();
    logic [31:0] mPc, mIr, mMdr, target, nxt;
    logic expWe;
    doReset();
    mPc = 0; mIr = 0; mMdr = 0;
    for (int i = 0; i < 300; i++) begin
      PCWrite_ctrl     = ($urandom_range(0, 3) == 0);
      PCWriteCond_ctrl = ($urandom_range(0, 1) == 0);
      BEQ_ctrl         = 1'($urandom_range(0, 1));
      alu_zero_in      = 1'($urandom_range(0, 1));
      PCSrc_ctrl       = 2'($urandom_range(0, 3));
      IRWrite_ctrl     = ($urandom_range(0, 2) == 0);
      alu_result_in    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      alu_out_in       = $urandom;
      mem_data_in      = $urandom;
      #1;
      expWe = PCWrite_ctrl || (PCWriteCond_ctrl && (BEQ_ctrl == alu_zero_in));
      compared++;
      if (pc_write_en_out !== expWe) begin
        mismatched++;
        $display("[TB] FAIL rand_we #%0d: got %b, required %b", i, pc_write_en_out, expWe);
      end
      target = (mPc & 32'hFC00_0000) | (mIr & 32'h03FF_FFFF);
      if (!expWe) nxt = mPc;
      else if (PCSrc_ctrl == 2'd0) nxt = alu_result_in;
      else if (PCSrc_ctrl == 2'd1) nxt = alu_out_in;
      else if (PCSrc_ctrl == 2'd2) nxt = target;
      else nxt = mPc;
      if (IRWrite_ctrl) mIr = mem_data_in;
      mMdr = mem_data_in;
      mPc = nxt;
      step();
      compared++;
      if (pc_out !== mPc || mdr_out !== mMdr) begin
        mismatched++;
        $display("[TB] FAIL rand_state #%0d: pc=%h mdr=%h, required %h %h", i, pc_out, mdr_out, mPc, mMdr);
      end
      compared++;
      if (Instruction_ctrlOut !== 6'(mIr >> 26) || rd_out !== 5'(mIr >> 21) || rs_out !== 5'(mIr >> 16)
          || rt_out !== 5'(mIr >> 11) || imm_out !== 16'(mIr)
          || jump_target_out !== ((mPc & 32'hFC00_0000) | (mIr & 32'h03FF_FFFF))) begin
        mismatched++;
        $display("[TB] FAIL rand_fields #%0d: op=%b rd=%0d rs=%0d rt=%0d imm=%h jt=%h, ir model %h pc model %h",
                 i, Instruction_ctrlOut, rd_out, rs_out, rt_out, imm_out, jump_target_out, mIr, mPc);
      end
    end
    idleInputs();
  endtask

`ifdef PC_IR_PERF_CNT_EN
  task automatic test_perf();
    int expCount;
    doReset();
    for (int i = 1; i <= 20; i++) begin
      IRWrite_ctrl = 1; mem_data_in = $urandom;
      step();
      expCount = (i > 15) ? 15 : i;
      compared++;
      if (instr_count_out !== CntW'(expCount)) begin
        mismatched++;
        $display("[TB] FAIL instr_count pulse %0d: got %0d, required %0d", i, instr_count_out, expCount);
      end
    end
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      PCWriteCond_ctrl = 1; BEQ_ctrl = 1; alu_zero_in = 1; PCSrc_ctrl = 2'b01; alu_out_in = 32'h40;
      step();
    end
    PCWrite_ctrl = 1;
    step();
    PCWrite_ctrl = 0; alu_zero_in = 0;
    step();
    idleInputs();
    compared++;
    if (branch_taken_count_out !== CntW'(3) || instr_count_out !== CntW'(15)) begin
      mismatched++;
      $display("[TB] FAIL branch_count: branches=%0d instrs=%0d, required 3 15", branch_taken_count_out, instr_count_out);
    end
  endtask
`endif

  initial begin
    reset = 1;
    idleInputs();
    #3;
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_reserved_and_async_reset();
    test_random();
`ifdef PC_IR_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
